// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared PC redirect codes, sequencer states and reset vector
package pc_pkg;

   localparam logic [1:0] PCSRC_SEQ  = 2'b00;
   localparam logic [1:0] PCSRC_REL  = 2'b01;
   localparam logic [1:0] PCSRC_RSV  = 2'b10;
   localparam logic [1:0] PCSRC_JALR = 2'b11;

   localparam logic [31:0] PC_RESET_VECTOR = 32'h0040_0000;

   typedef enum logic [1:0] {
      PCS_HOLD = 2'd0,
      PCS_RUN  = 2'd1,
      PCS_PEND = 2'd2,
      PCS_HALT = 2'd3
   } pcs_state_t;

endpackage

// File: rtl/pc_target_mux.sv
// rtl/pc_target_mux.sv - redirect decode, target select and alignment check
module pc_target_mux
   import pc_pkg::*;
(
   input  logic [1:0]  PCSrc,
   input  logic        ExValid,
   input  logic [31:0] PCE,
   input  logic [31:0] ExtImm,
   input  logic [31:0] ALUResult,
   output logic        redirect,
   output logic [31:0] target,
   output logic        misaligned
);

   always_comb begin
      redirect = 1'b0;
      target   = PCE + ExtImm;
      case (PCSrc)
         PCSRC_REL: begin
            redirect = ExValid;
            target   = PCE + ExtImm;
         end
         PCSRC_JALR: begin
            redirect = ExValid;
            target   = ALUResult & ~32'h1;
         end
         default: redirect = 1'b0;
      endcase
   end

   assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC owner: fetch handshake, redirects, misalign trap
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic [1:0]  PCSrc,
   input  logic        ExValid,
   input  logic [31:0] PCE,
   input  logic [31:0] ExtImm,
   input  logic [31:0] ALUResult,
   output logic        IFetchReq,
   output logic [31:0] IFetchAddr,
   input  logic        IFetchAck,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        MisalignTrap,
   output logic [31:0] TrapAddr
);

   pcs_state_t  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] taddr_q, taddr_d;
   logic        trap_q, trap_d;
   logic        req_q, req_d;

   logic        redirect;
   logic        misaligned;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   pc_target_mux u_target (
      .PCSrc      (PCSrc),
      .ExValid    (ExValid),
      .PCE        (PCE),
      .ExtImm     (ExtImm),
      .ALUResult  (ALUResult),
      .redirect   (redirect),
      .target     (target),
      .misaligned (misaligned)
   );

   assign pc_plus4 = pc_q + 32'd4;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= PCS_HOLD;
         pc_q    <= RESET_VECTOR;
         pend_q  <= 32'h0;
         taddr_q <= 32'h0;
         trap_q  <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         taddr_q <= taddr_d;
         trap_q  <= trap_d;
         req_q   <= req_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      taddr_d = taddr_q;
      trap_d  = trap_q;
      case (state_q)
         PCS_HOLD: state_d = PCS_RUN;
         PCS_RUN: begin
            if (redirect && misaligned) begin
               state_d = PCS_HALT;
               trap_d  = 1'b1;
               taddr_d = target;
            end else if (redirect && IFetchAck) begin
               pc_d = target;
            end else if (redirect) begin
               // Address must stay put while the current request is unacked.
               pend_d  = target;
               state_d = PCS_PEND;
            end else if (IFetchAck) begin
               pc_d = pc_plus4;
            end
         end
         PCS_PEND: begin
            if (redirect && misaligned) begin
               state_d = PCS_HALT;
               trap_d  = 1'b1;
               taddr_d = target;
            end else if (IFetchAck) begin
               pc_d    = redirect ? target : pend_q;
               state_d = PCS_RUN;
            end else if (redirect) begin
               pend_d = target;
            end
         end
         PCS_HALT: state_d = PCS_HALT;
         default:  state_d = PCS_HOLD;
      endcase
      req_d = (state_d == PCS_RUN) || (state_d == PCS_PEND);
   end

   assign PC           = pc_q;
   assign IFetchAddr   = pc_q;
   assign PCPlus4      = pc_plus4;
   assign IFetchReq    = req_q;
   assign MisalignTrap = trap_q;
   assign TrapAddr     = taddr_q;

endmodule
